// File: rtl/four_to_two_priority_encoder_if.sv
// Request/code bundle for the sequential 4-to-2 priority encoder.
// The master side drives requests and ready; the slave side returns code, valid and status.
interface four_to_two_priority_encoder_if #(
  parameter int unsigned CNT_W = 8
);
  logic             e;
  logic             x0;
  logic             x1;
  logic             x2;
  logic             x3;
  logic             rdy;
  logic             v;
  logic             y0;
  logic             y1;
  logic             a;
  logic [CNT_W-1:0] d;

  modport master (
    output e, x0, x1, x2, x3, rdy,
    input  v, y0, y1, a, d
  );

  modport slave (
    input  e, x0, x1, x2, x3, rdy,
    output v, y0, y1, a, d
  );
endinterface

// File: rtl/four_to_two_priority_encoder.sv
// Sequential 4-to-2 priority encoder: sticky pending requests issued one code at a time over
// valid/ready. Define FOUR_TO_TWO_RR_EN for round-robin selection instead of fixed priority.
module four_to_two_priority_encoder #(
  parameter int unsigned CNT_W     = 8,
  parameter bit          LOW_FIRST = 1'b0
) (
  input logic                          clk,
  input logic                          rst_n,
  four_to_two_priority_encoder_if.slave bus
);

  localparam logic [CNT_W-1:0] DMax = {CNT_W{1'b1}};

  logic [3:0]       p_q, p_d;
  logic [1:0]       y_q, y_d;
  logic             v_q, v_d;
  logic [CNT_W-1:0] d_q, d_d;

  logic [3:0]       req;
  logic [1:0]       sel;
  logic [3:0]       g;
  logic             load;
  logic [3:0]       drop;
  logic [2:0]       drop_cnt;
  logic [CNT_W+2:0] d_sum;

  assign req = bus.e ? {bus.x3, bus.x2, bus.x1, bus.x0} : 4'b0000;

`ifdef FOUR_TO_TWO_RR_EN
  logic [1:0] r_q, r_d;
  logic [1:0] idx;

  // Scan downwards so the last hit is the first set bit at or after the pointer.
  always_comb begin
    sel = 2'd0;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = r_q + 2'(k);
      if (p_q[idx]) sel = idx;
    end
  end

  always_comb begin
    r_d = r_q;
    if (load) r_d = sel + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= 2'd0;
    else        r_q <= r_d;
  end
`else
  always_comb begin
    sel = 2'd0;
    if (LOW_FIRST) begin
      for (int i = 3; i >= 0; i--) begin
        if (p_q[i]) sel = 2'(i);
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (p_q[i]) sel = 2'(i);
      end
    end
  end
`endif

  assign g    = (|p_q) ? (4'b0001 << sel) : 4'b0000;
  assign load = (|p_q) & (~v_q | bus.rdy);

  // A request landing on the line being granted this edge re-pends rather than counting as dropped.
  assign drop     = req & p_q & ~(load ? g : 4'b0000);
  assign drop_cnt = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
  assign d_sum    = (CNT_W+3)'(d_q) + (CNT_W+3)'(drop_cnt);

  always_comb begin
    p_d = (p_q & ~(load ? g : 4'b0000)) | req;
    y_d = y_q;
    v_d = v_q;
    d_d = (d_sum > (CNT_W+3)'(DMax)) ? DMax : d_sum[CNT_W-1:0];
    if (load) begin
      y_d = sel;
      v_d = 1'b1;
    end else if (v_q && bus.rdy) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= 4'b0000;
      y_q <= 2'b00;
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      p_q <= p_d;
      y_q <= y_d;
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign bus.v  = v_q;
  assign bus.y0 = y_q[0];
  assign bus.y1 = y_q[1];
  assign bus.a  = |p_q;
  assign bus.d  = d_q;

endmodule
